// File: rtl/ahb_lite_ram_bridge.sv
// AHB-Lite slave front-end driving a single-port-style RAM strobe interface.
// Writes finish with no wait state, reads with one, illegal transfers get a two-cycle ERROR.
module ahb_lite_ram_bridge #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           RAM_ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE       = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hsel,
  input  logic [ADDR_WIDTH-1:0]     haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [DATA_WIDTH-1:0]     hwdata,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [DATA_WIDTH-1:0]     hrdata,
  output logic                      wr_enb,
  output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      rd_enb,
  output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]     rd_data
);

  localparam int unsigned WORD_LSB  = 2;
  localparam int unsigned TAG_LSB   = RAM_ADDR_WIDTH + WORD_LSB;
  localparam logic [2:0]  SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DP,
    S_RD_ISSUE,
    S_RD_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                    r_state;
  logic                      r_hreadyout;
  logic                      r_hresp;
  logic                      r_wr_enb;
  logic                      r_rd_enb;
  logic [RAM_ADDR_WIDTH-1:0] r_wr_addr;
  logic [RAM_ADDR_WIDTH-1:0] r_rd_addr;

  logic                      w_can_accept;
  logic                      w_accept;
  logic                      w_aligned;
  logic                      w_in_range;
  logic                      w_legal;
  logic [RAM_ADDR_WIDTH-1:0] w_word;
  logic                      w_unused_htrans;

  // Only states that are completing (or idle) may take a new address phase.
  assign w_can_accept    = (r_state != S_RD_ISSUE) && (r_state != S_ERR1);
  assign w_accept        = hsel && htrans[1] && hready && w_can_accept;
  assign w_aligned       = (haddr[WORD_LSB-1:0] == '0);
  // RAM_BASE is aligned to the window size, so the window is a tag match on the upper bits.
  assign w_in_range      = (haddr[ADDR_WIDTH-1:TAG_LSB] == RAM_BASE[ADDR_WIDTH-1:TAG_LSB]);
  assign w_legal         = (hsize == SIZE_WORD) && w_aligned && w_in_range;
  assign w_word          = haddr[TAG_LSB-1:WORD_LSB];
  assign w_unused_htrans = htrans[0];

  // State and strobe registers; each registered output holds the value for the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_wr_enb    <= 1'b0;
      r_rd_enb    <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
    end else begin
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_wr_enb    <= 1'b0;
      r_rd_enb    <= 1'b0;
      case (r_state)
        S_RD_ISSUE: begin
          r_state <= S_RD_DATA;
        end
        S_ERR1: begin
          r_state <= S_ERR2;
          r_hresp <= 1'b1;
        end
        default: begin
          if (!w_accept) begin
            r_state <= S_IDLE;
          end else if (!w_legal) begin
            r_state     <= S_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end else if (hwrite) begin
            r_state   <= S_WR_DP;
            r_wr_enb  <= 1'b1;
            r_wr_addr <= w_word;
          end else begin
            r_state     <= S_RD_ISSUE;
            r_hreadyout <= 1'b0;
            r_rd_enb    <= 1'b1;
            r_rd_addr   <= w_word;
          end
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign wr_enb    = r_wr_enb;
  assign wr_addr   = r_wr_addr;
  assign rd_enb    = r_rd_enb;
  assign rd_addr   = r_rd_addr;

  // Data buses pass straight through during their data phase, zero otherwise.
  assign wr_data = (r_state == S_WR_DP)   ? hwdata  : '0;
  assign hrdata  = (r_state == S_RD_DATA) ? rd_data : '0;

endmodule

// File: tb/tb_ahb_lite_ram_bridge.sv
// Bench for ahb_lite_ram_bridge: directed cycle table, reset corner cases,
// then random AHB traffic against a transfer-level response model.
module tb_ahb_lite_ram_bridge;

  logic        clk;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        wr_enb;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_enb;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;

  int n_total = 0;
  int n_bad   = 0;

  ahb_lite_ram_bridge dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM attached to the bridge: registered read, cleared by reset.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      rd_data <= 32'h0;
    end else begin
      if (wr_enb) ram[wr_addr] <= wr_data;
      if (rd_enb) rd_data <= ram[rd_addr];
    end
  end

  typedef struct packed {
    logic        ro;
    logic        rs;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic [31:0] rd;
  } exp_t;

  typedef struct packed {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    exp_t        e;
  } vec_t;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] W  = 3'b010;

  function automatic exp_t mk(input logic ro, input logic rs, input logic we,
                              input logic [7:0] wa, input logic [31:0] wd,
                              input logic re, input logic [7:0] ra, input logic [31:0] rd);
    exp_t e;
    e.ro = ro; e.rs = rs; e.we = we; e.wa = wa; e.wd = wd;
    e.re = re; e.ra = ra; e.rd = rd;
    return e;
  endfunction

  function automatic exp_t e_idle();             return mk(1, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic exp_t e_wr(input logic [7:0] a, input logic [31:0] d);
    return mk(1, 0, 1, a, d, 0, 0, 0);
  endfunction
  function automatic exp_t e_rdi(input logic [7:0] a) ; return mk(0, 0, 0, 0, 0, 1, a, 0); endfunction
  function automatic exp_t e_rdd(input logic [31:0] d); return mk(1, 0, 0, 0, 0, 0, 0, d); endfunction
  function automatic exp_t e_err1();             return mk(0, 1, 0, 0, 0, 0, 0, 0); endfunction
  function automatic exp_t e_err2();             return mk(1, 1, 0, 0, 0, 0, 0, 0); endfunction

  function automatic vec_t vin(input logic s, input logic [1:0] t, input logic w,
                               input logic [2:0] z, input logic [31:0] a,
                               input logic [31:0] d, input logic r, input exp_t e);
    vec_t v;
    v.hsel = s; v.htrans = t; v.hwrite = w; v.hsize = z;
    v.haddr = a; v.hwdata = d; v.hready = r; v.e = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    hsel = v.hsel; htrans = v.htrans; hwrite = v.hwrite; hsize = v.hsize;
    haddr = v.haddr; hwdata = v.hwdata; hready = v.hready;
  endtask

  task automatic check(input string name, input exp_t e);
    logic ok;
    ok = (hreadyout === e.ro) && (hresp === e.rs) && (wr_enb === e.we) &&
         (rd_enb === e.re) && (hrdata === e.rd);
    if (e.we) ok = ok && (wr_addr === e.wa) && (wr_data === e.wd);
    if (e.re) ok = ok && (rd_addr === e.ra);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got ro=%0b rs=%0b we=%0b wa=%h wd=%h re=%0b ra=%h rd=%h | want ro=%0b rs=%0b we=%0b wa=%h wd=%h re=%0b ra=%h rd=%h",
               name, hreadyout, hresp, wr_enb, wr_addr, wr_data, rd_enb, rd_addr, hrdata,
               e.ro, e.rs, e.we, e.wa, e.wd, e.re, e.ra, e.rd);
    end
  endtask

  initial begin : main
    vec_t        tbl [29];
    exp_t        q [$];
    exp_t        cur;
    logic [31:0] ref_mem [256];
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  sz;
    logic        acc;
    logic        legal;
    int          k;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // write/read 0x10; burst writes then reads; error cases; non-accepted phases
    tbl[0]  = vin(1, NS, 1, W, 32'h10,  32'h0,         1, e_idle());
    tbl[1]  = vin(1, NS, 0, W, 32'h10,  32'hDEAD_BEEF, 1, e_wr(8'h04, 32'hDEAD_BEEF));
    tbl[2]  = vin(0, ID, 0, W, 32'h0,   32'h5A5A_5A5A, 0, e_rdi(8'h04));
    tbl[3]  = vin(0, ID, 0, W, 32'h0,   32'h0,         1, e_rdd(32'hDEAD_BEEF));
    tbl[4]  = vin(0, ID, 0, W, 32'h0,   32'h0,         1, e_idle());
    tbl[5]  = vin(1, NS, 1, W, 32'h0,   32'h0,         1, e_idle());
    tbl[6]  = vin(1, SQ, 1, W, 32'h4,   32'h1111_1111, 1, e_wr(8'h00, 32'h1111_1111));
    tbl[7]  = vin(1, SQ, 1, W, 32'h8,   32'h2222_2222, 1, e_wr(8'h01, 32'h2222_2222));
    tbl[8]  = vin(1, NS, 0, W, 32'h0,   32'h3333_3333, 1, e_wr(8'h02, 32'h3333_3333));
    tbl[9]  = vin(1, SQ, 0, W, 32'h4,   32'h0,         0, e_rdi(8'h00));
    tbl[10] = vin(1, SQ, 0, W, 32'h4,   32'h0,         1, e_rdd(32'h1111_1111));
    tbl[11] = vin(1, SQ, 0, W, 32'h8,   32'h0,         0, e_rdi(8'h01));
    tbl[12] = vin(1, SQ, 0, W, 32'h8,   32'h0,         1, e_rdd(32'h2222_2222));
    tbl[13] = vin(0, ID, 0, W, 32'h0,   32'h0,         0, e_rdi(8'h02));
    tbl[14] = vin(0, ID, 0, W, 32'h0,   32'h0,         1, e_rdd(32'h3333_3333));
    tbl[15] = vin(1, NS, 1, W, 32'h402, 32'h0,         1, e_idle());
    tbl[16] = vin(1, NS, 1, W, 32'h20,  32'h7777_7777, 1, e_err1());
    tbl[17] = vin(0, ID, 0, W, 32'h0,   32'h8888_8888, 1, e_err2());
    tbl[18] = vin(1, NS, 0, W, 32'h400, 32'h0,         1, e_idle());
    tbl[19] = vin(0, ID, 0, W, 32'h0,   32'h0,         0, e_err1());
    tbl[20] = vin(1, NS, 0, 3'b000, 32'h4, 32'h0,      1, e_err2());
    tbl[21] = vin(0, ID, 0, W, 32'h0,   32'h0,         0, e_err1());
    tbl[22] = vin(0, ID, 0, W, 32'h0,   32'h0,         1, e_err2());
    tbl[23] = vin(0, ID, 0, W, 32'h0,   32'h0,         1, e_idle());
    tbl[24] = vin(1, BZ, 1, W, 32'h0,   32'h0,         1, e_idle());
    tbl[25] = vin(1, NS, 1, W, 32'h0,   32'h0,         0, e_idle());
    tbl[26] = vin(0, NS, 1, W, 32'h0,   32'h0,         1, e_idle());
    tbl[27] = vin(1, ID, 0, W, 32'h0,   32'h0,         1, e_idle());
    tbl[28] = vin(0, ID, 0, W, 32'h0,   32'h0,         1, e_idle());

    rst = 1'b1;
    drive(vin(0, ID, 0, W, 32'h0, 32'h0, 1, e_idle()));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", e_idle());
    n_total++;
    if (wr_addr !== 8'h0 || rd_addr !== 8'h0 || wr_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_regs: got wa=%h ra=%h wd=%h want 0 0 0", wr_addr, rd_addr, wr_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      @(negedge clk);
      check($sformatf("row%0d", i), tbl[i].e);
    end

    // reset during a write data phase
    @(posedge clk);
    #1 drive(vin(1, NS, 1, W, 32'h40, 32'h0, 1, e_idle()));
    @(posedge clk);
    #1 drive(vin(0, ID, 0, W, 32'h0, 32'hAAAA_5555, 1, e_idle()));
    rst = 1'b1;
    @(negedge clk);
    check("rst_wr_dp", e_wr(8'h10, 32'hAAAA_5555));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_after", e_idle());

    // reset during read issue
    @(posedge clk);
    #1 drive(vin(1, NS, 0, W, 32'h44, 32'h0, 1, e_idle()));
    @(posedge clk);
    #1 drive(vin(0, ID, 0, W, 32'h0, 32'h0, 0, e_idle()));
    rst = 1'b1;
    @(negedge clk);
    check("rst_rd_issue", e_rdi(8'h11));
    @(posedge clk);
    #1 rst = 1'b0;
    hready = 1'b1;
    @(negedge clk);
    check("rst_rd_after", e_idle());
    @(posedge clk);
    @(negedge clk);
    check("rst_rd_after2", e_idle());

    // random traffic; the bench RAM was cleared by the resets above
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      cur = (q.size() > 0) ? q.pop_front() : e_idle();
      if (cur.we) ref_mem[cur.wa] = cur.wd;
      hready = cur.ro ? ($urandom_range(0, 9) != 0) : 1'b0;
      hsel   = ($urandom_range(0, 9) != 0);
      htrans = 2'($urandom_range(0, 3));
      hwrite = 1'($urandom_range(0, 1));
      sz     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : W;
      hsize  = sz;
      k = $urandom_range(0, 9);
      if (k < 7)       a = 32'($urandom_range(0, 255)) * 4;
      else if (k == 7) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      else if (k == 8) a = 32'h400 + 32'($urandom_range(0, 1023));
      else             a = $urandom;
      haddr  = a;
      hwdata = cur.we ? cur.wd : $urandom;
      acc = hsel && htrans[1] && hready;
      if (acc) begin
        legal = (sz == 3'b010) && (a % 4 == 0) && (a < 32'd1024);
        if (!legal) begin
          q.push_back(e_err1());
          q.push_back(e_err2());
        end else if (hwrite) begin
          d = $urandom;
          q.push_back(e_wr(8'(a / 4), d));
        end else begin
          q.push_back(e_rdi(8'(a / 4)));
          q.push_back(e_rdd(ref_mem[a / 4]));
        end
      end
      @(negedge clk);
      check($sformatf("rand%0d", cyc), cur);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
